// File: rtl/encoder_pkg.sv
// Shared constants and types for the quadrature encoder duty controller:
// Gray-code state encoding, sub-step accumulator sizing and acceleration constants.
package encoder_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_e;

  typedef enum logic [1:0] {
    MOVE_NONE = 2'b00,
    MOVE_CW   = 2'b01,
    MOVE_CCW  = 2'b10,
    MOVE_ERR  = 2'b11
  } quad_move_e;

  // Signed sub-step accumulator; a detent is four quarter-steps in one direction.
  localparam int ACC_W      = 3;
  localparam int ACC_DETENT = 4;

  localparam int ACCEL_INTERVAL_W = 16;
  localparam int ACCEL_MULT       = 8;

  function automatic quad_state_e quad_cw_next(input quad_state_e cur);
    quad_state_e nxt;
    case (cur)
      S00:     nxt = S01;
      S01:     nxt = S11;
      S11:     nxt = S10;
      S10:     nxt = S00;
      default: nxt = S00;
    endcase
    return nxt;
  endfunction

  function automatic quad_move_e quad_decode(input quad_state_e cur, input logic [1:0] nxt);
    quad_move_e mv;
    if (nxt == cur) begin
      mv = MOVE_NONE;
    end else if ((nxt ^ cur) == 2'b11) begin
      mv = MOVE_ERR;
    end else if (nxt == quad_cw_next(cur)) begin
      mv = MOVE_CW;
    end else begin
      mv = MOVE_CCW;
    end
    return mv;
  endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit debouncer: the accepted level follows the input only after it has
// differed from the accepted level for DEB_CYCLES consecutive cycles.
module debounce_bit #(
  parameter int DEB_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          lvl_q, lvl_d;

  // Any return to the accepted level restarts the stability count.
  always_comb begin
    cnt_d = cnt_q;
    lvl_d = lvl_q;
    if (d_i == lvl_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      lvl_d = d_i;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      lvl_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      lvl_q <= lvl_d;
    end
  end

  assign q_o = lvl_q;

endmodule

// File: rtl/encoder_duty_ctrl.sv
// Rotary encoder to PWM duty value: synchronize, debounce, decode quadrature, count detents.
// Optional detent acceleration is enabled by defining ENCODER_ACCEL_EN.
module encoder_duty_ctrl
  import encoder_pkg::*;
#(
  parameter int CNT_W      = 19,
  parameter int CNT_MAX    = 500000,
  parameter int STEP       = 5000,
  parameter int DEB_CYCLES = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       encoder,
  input  logic             encoder_btn,
  output logic [CNT_W-1:0] contador,
  output logic             dir,
  output logic             quad_err
);

  localparam logic [CNT_W:0]   CNT_MAX_X  = (CNT_W+1)'(CNT_MAX);
  localparam logic [CNT_W:0]   STEP_X     = (CNT_W+1)'(STEP);
  localparam logic [ACC_W:0]   ACC_POS    = (ACC_W+1)'(ACC_DETENT);
  localparam logic [ACC_W:0]   ACC_NEG    = (ACC_W+1)'(-ACC_DETENT);

  logic [2:0] sync1_q, sync2_q;
  logic [1:0] enc_deb_s;
  logic       btn_deb_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= {encoder_btn, encoder};
      sync2_q <= sync1_q;
    end
  end

  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk(clk), .rst_n(rst_n), .d_i(sync2_q[0]), .q_o(enc_deb_s[0])
  );
  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk(clk), .rst_n(rst_n), .d_i(sync2_q[1]), .q_o(enc_deb_s[1])
  );
  debounce_bit #(.DEB_CYCLES(DEB_CYCLES)) u_deb_btn (
    .clk(clk), .rst_n(rst_n), .d_i(sync2_q[2]), .q_o(btn_deb_s)
  );

  quad_state_e state_q, state_d;
  quad_move_e  move_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S00;
    end else begin
      state_q <= state_d;
    end
  end

  // Even an illegal jump lands the FSM on the observed phase pair.
  always_comb begin
    state_d = quad_state_e'(enc_deb_s);
  end

  always_comb begin
    move_s = quad_decode(state_q, enc_deb_s);
  end

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum_s;
  logic             detent_cw_s, detent_ccw_s;

  // Sum is one bit wider so that +4 is representable before the detent clears it.
  always_comb begin
    acc_sum_s = {acc_q[ACC_W-1], acc_q};
    case (move_s)
      MOVE_CW:  acc_sum_s = {acc_q[ACC_W-1], acc_q} + (ACC_W+1)'(1);
      MOVE_CCW: acc_sum_s = {acc_q[ACC_W-1], acc_q} - (ACC_W+1)'(1);
      default:  acc_sum_s = {acc_q[ACC_W-1], acc_q};
    endcase
    detent_cw_s  = (move_s == MOVE_CW)  && (acc_sum_s == ACC_POS);
    detent_ccw_s = (move_s == MOVE_CCW) && (acc_sum_s == ACC_NEG);
    if (move_s == MOVE_ERR || detent_cw_s || detent_ccw_s) begin
      acc_d = '0;
    end else begin
      acc_d = acc_sum_s[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  logic           btn_prev_q;
  logic           btn_rise_s;
  logic [CNT_W:0] step_s;
  logic [CNT_W:0] cnt_ext_s, cnt_up_s, cnt_dn_s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           err_q;

  assign btn_rise_s = btn_deb_s & ~btn_prev_q;

`ifdef ENCODER_ACCEL_EN
  localparam logic [ACCEL_INTERVAL_W:0] GAP_MAX   = (ACCEL_INTERVAL_W+1)'(1 << ACCEL_INTERVAL_W);
  localparam logic [CNT_W:0]            STEP_FAST = (CNT_W+1)'(ACCEL_MULT * STEP);

  logic [ACCEL_INTERVAL_W:0] gap_q, gap_d;
  logic                      fast_s;

  // Cycles since the last accepted detent, parked at GAP_MAX so reset never accelerates.
  always_comb begin
    fast_s = (gap_q < GAP_MAX) && ((detent_cw_s && dir_q) || (detent_ccw_s && !dir_q));
    step_s = fast_s ? STEP_FAST : STEP_X;
    if ((detent_cw_s || detent_ccw_s) && !btn_rise_s) begin
      gap_d = '0;
    end else if (gap_q != GAP_MAX) begin
      gap_d = gap_q + (ACCEL_INTERVAL_W+1)'(1);
    end else begin
      gap_d = gap_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_q <= GAP_MAX;
    end else begin
      gap_q <= gap_d;
    end
  end
`else
  always_comb begin
    step_s = STEP_X;
  end
`endif

  // Saturating add/subtract in CNT_W+1 bits; a button press overrides a same-cycle detent.
  always_comb begin
    cnt_ext_s = {1'b0, cnt_q};
    cnt_up_s  = cnt_ext_s + step_s;
    if (cnt_up_s > CNT_MAX_X) begin
      cnt_up_s = CNT_MAX_X;
    end else begin
      cnt_up_s = cnt_up_s;
    end
    if (cnt_ext_s < step_s) begin
      cnt_dn_s = '0;
    end else begin
      cnt_dn_s = cnt_ext_s - step_s;
    end
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (btn_rise_s) begin
      cnt_d = '0;
    end else if (detent_cw_s) begin
      cnt_d = cnt_up_s[CNT_W-1:0];
      dir_d = 1'b1;
    end else if (detent_ccw_s) begin
      cnt_d = cnt_dn_s[CNT_W-1:0];
      dir_d = 1'b0;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      dir_q      <= 1'b1;
      err_q      <= 1'b0;
      btn_prev_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dir_q      <= dir_d;
      err_q      <= (move_s == MOVE_ERR);
      btn_prev_q <= btn_deb_s;
    end
  end

  assign contador = cnt_q;
  assign dir      = dir_q;
  assign quad_err = err_q;

endmodule

// File: doc/encoder_duty_ctrl.md
ENCODER_DUTY_CTRL -- requirements
Module: encoder_duty_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 19, width of contador.
REQ-002 SHALL have parameter CNT_MAX, default 500000, saturation ceiling of contador.
REQ-003 SHALL have parameter STEP, default 5000, contador change per detent.
REQ-004 SHALL have parameter DEB_CYCLES, default 1000, clock cycles an input must hold stable to be accepted.
REQ-005 SHALL have port clk  input  1  sole clock, all flops rising-edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port encoder  input  2  raw quadrature phases, bit0 = A, bit1 = B, asynchronous.
REQ-008 SHALL have port encoder_btn  input  1  raw push button, active-high, asynchronous.
REQ-009 SHALL have port contador  output  CNT_W  registered duty value for the downstream PWM stage.
REQ-010 SHALL have port dir  output  1  direction of last accepted detent, 1 = CW.
REQ-011 SHALL have port quad_err  output  1  one-cycle pulse on illegal quadrature transition.

Function
REQ-012 SHALL pass encoder[1:0] and encoder_btn each through a 2-flop synchronizer.
REQ-013 SHALL debounce each synchronized bit independently: accepted value updates only after DEB_CYCLES consecutive cycles of a differing stable level; any glitch restarts the count.
REQ-014 SHALL decode debounced {B,A} with 4-state Gray FSM S00->S01->S11->S10->S00 = CW, reverse order = CCW.
REQ-015 SHALL keep a signed 3-bit sub-step accumulator; a detent is recognized when it reaches +4 (CW) or -4 (CCW), then cleared to 0.
REQ-016 SHALL treat a transition changing both bits as illegal: pulse quad_err, move FSM to the new state, clear accumulator, no contador change.
REQ-017 SHALL add STEP on CW detent saturating at CNT_MAX, subtract STEP on CCW detent saturating at 0; arithmetic done in CNT_W+1 bits, no wrap-around.
REQ-018 SHALL update contador and dir on the cycle after detent recognition (one-cycle latency from final debounced edge).
REQ-019 SHALL clear contador to 0 on the rising edge of debounced button; button edge wins over a detent in the same cycle (detent discarded).
REQ-020 SHALL leave contador unchanged when a CCW detent occurs at 0 or a CW detent at CNT_MAX.

Reset
REQ-021 SHALL on rst_n low asynchronously set contador = 0, dir = 1, quad_err = 0, accumulator = 0, debounce counters = 0, debounced/synchronized values = 0, FSM = S00.
REQ-022 SHALL discard any partially accumulated detent when reset asserts mid-rotation; first detent after release requires four fresh transitions.

Configuration
REQ-023 SHALL, when ENCODER_ACCEL_EN is defined, use step 8*STEP for a detent arriving within 2^16 cycles of the previous same-direction detent, still saturating per REQ-017.
REQ-024 SHALL, when ENCODER_ACCEL_EN is undefined, always use STEP and contain no interval timer logic.

Structure
REQ-025 SHALL place quadrature state encoding, accumulator width and accel interval/multiplier constants in shared package encoder_pkg.
REQ-026 SHALL implement debounce as sub-module debounce_bit (parameter DEB_CYCLES), instantiated three times.

Verification (bench DEB_CYCLES=4, CNT_MAX=20, STEP=5)
REQ-027 SHALL verify: reset release, no stimulus -> contador=0, dir=1, quad_err=0.
REQ-028 SHALL verify: four full CW detents -> contador 5,10,15,20; fifth CW -> stays 20.
REQ-029 SHALL verify: from 20, five CCW detents -> 15,10,5,0,0, dir=0.
REQ-030 SHALL verify: 2-cycle glitch on A -> no FSM change, contador unchanged.
REQ-031 SHALL verify: 00->11 jump -> quad_err one-cycle pulse, contador unchanged; button press at 15 coinciding with detent -> contador=0.
REQ-032 SHALL verify: ENCODER_ACCEL_EN, CNT_MAX=100, two CW detents 100 cycles apart -> 5 then 45; rst_n low after two CW transitions -> next two transitions produce no detent.
